ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives raw PS/2 keyboard frames and turns them into the paddle, start and mode controls used by the game. It sits directly upstream of the animation/score logic in `main_control`, running on the 50 MHz `clk_50` domain. Its outputs are:

- eight held-key levels, one up and one down per paddle;
- a one-cycle `start_ball` pulse;
- a `state` mode toggle;
- a `key_release` pulse.

It synchronizes and filters the PS/2 lines, deframes 11-bit frames with parity check, and tracks the E0 (extended) and F0 (break) prefixes.

## Interface

Parameters:

- `FILTER_LEN`, default 8: consecutive identical synchronized `ps2c` samples required before the filtered clock changes.
- `TIMEOUT`, default 50000: cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:

- `clk` input 1: 50 MHz system clock. This is the only clock.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `ps2d` input 1: PS/2 data line, asynchronous.
- `ps2c` input 1: PS/2 clock line, asynchronous.
- `KEY_UP_1`, `KEY_DOWN_1` output 1 each: W (1D) / S (1B) held.
- `KEY_UP_2`, `KEY_DOWN_2` output 1 each: extended up arrow (E0 75) / extended down arrow (E0 72) held.
- `KEY_UP_3`, `KEY_DOWN_3` output 1 each: T (2C) / G (34) held.
- `KEY_UP_4`, `KEY_DOWN_4` output 1 each: keypad 8 (75) / keypad 2 (72) held. These are the non-extended codes.
- `start_ball` output 1: one-cycle pulse on the first make of Space (29).
- `state` output 1: mode flag, toggled on the first make of Esc (76).
- `key_release` output 1: one-cycle pulse on any complete break sequence.
- `frame_err` output 1: one-cycle pulse on a bad start, parity or stop bit, or a timeout.

## Operation

Input conditioning:

- `ps2c` and `ps2d` each pass through a 2-FF synchronizer.
- Filtered clock `fc`: it takes the synchronized value only after `FILTER_LEN` consecutive equal samples. It resets to 1.
- A falling edge of `fc` is a one-cycle strobe `fall`. `ps2d` is sampled only on `fall`.

Receiver FSM (states IDLE, DATA, PARITY, STOP):

- IDLE: on `fall` with data 0, go to DATA with bit count 0. On `fall` with data 1, pulse `frame_err` and stay in IDLE.
- DATA: shift data in LSB first, 8 bits. After bit 7, go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: require stop bit = 1 and odd parity over data+parity. If both hold, raise `rx_done` for one cycle with `rx_byte`. Otherwise pulse `frame_err`. Either way, return to IDLE.
- Timeout counter: cleared on every `fall` and held at 0 in IDLE. If it reaches `TIMEOUT` in any non-IDLE state, go to IDLE and pulse `frame_err`.

Decoder, acting on `rx_done`:

- Byte E0 sets `ext`. Byte F0 sets `brk`. Prefixes accumulate in any order.
- Any other byte is a code: look up (`ext`, code).
  - If `brk`=0: set the matching held flag.
  - If `brk`=1: clear the matching held flag and pulse `key_release`.
  - Then clear `ext` and `brk`.
- Unmapped codes change no flags. A break of an unmapped code still pulses `key_release`.
- Space and Esc keep internal held flags:
  - `start_ball` pulses and `state` toggles only when a make arrives while the flag is 0.
  - Typematic repeats do nothing.
- `frame_err` clears `ext` and `brk`. Held flags are kept.
- Extended 75/72 drive paddle 2 only. Non-extended 75/72 drive paddle 4 only.

Reset (`reset`=0 at a `clk` edge):

- All outputs go to 0.
- `fc` goes to 1.
- FSM goes to IDLE.
- Prefixes, held flags and counters go to 0.
- A reset mid-frame discards the partial frame. No `frame_err` is produced.

## Timing

- The synchronizer adds 2 cycles and the filter adds `FILTER_LEN` cycles from a `ps2c` transition to `fall`.
- Stop-bit `fall` at cycle T: `rx_done`/`frame_err` at T+1. Key levels, `start_ball`, `key_release` and `state` update at T+2.
- `start_ball`, `key_release` and `frame_err` are exactly one cycle wide.
- All outputs are registered. Input edges to outputs have no combinational path.
- A make and a break of different keys in consecutive frames are handled independently. Frames are far slower than the 2-cycle decode, so no overlap occurs.

## Test plan

- Reset, then frame 1D with correct parity: `KEY_UP_1`=1 at T+2. Then F0,1D: `KEY_UP_1`=0 and one `key_release` pulse.
- E0 75 then 75: `KEY_UP_2`=1 and `KEY_UP_4`=1. Then E0 F0 75: only `KEY_UP_2` clears.
- Space make sent three times (typematic): exactly one `start_ball` pulse. Then F0 29 followed by 29: a second pulse.
- Frame 1D with wrong parity: `frame_err` pulse and no flag change. Then E0 followed by a bad frame, then 75: `KEY_UP_4`=1, proving the prefix was cleared.
- Stop the PS/2 clock after 4 bits for 60000 cycles: `frame_err` pulse once and FSM back to IDLE. The next valid 2C sets `KEY_UP_3`.
- Assert `reset`=0 mid-frame while `KEY_DOWN_1` and `state` are 1: all outputs 0 on the next cycle. Glitch pulses shorter than `FILTER_LEN` on `ps2c` produce no `fall`.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns raw PS/2 keyboard frames into game controls: four paddles with an
//   up/down held level each, a start pulse on Space, a mode toggle on Esc,
//   a pulse on every key release and a pulse on every malformed frame.
//
// Ports
//   clk          50 MHz system clock (only clock)
//   reset        synchronous, active-low
//   ps2d, ps2c   raw PS/2 data / clock lines (asynchronous)
//   KEY_UP_n     paddle n up key held   (1: W, 2: E0 75, 3: T, 4: keypad 8)
//   KEY_DOWN_n   paddle n down key held (1: S, 2: E0 72, 3: G, 4: keypad 2)
//   start_ball   one-cycle pulse on the first make of Space
//   state        mode flag, toggled on the first make of Esc
//   key_release  one-cycle pulse on every complete break sequence
//   frame_err    one-cycle pulse on bad start/parity/stop bit or timeout
//
// Parameters
//   FILTER_LEN   consecutive equal ps2c samples needed to move the filtered clock
//   TIMEOUT      idle cycles after which a partial frame is abandoned

module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2d,
  input  logic ps2c,
  output logic KEY_UP_1,
  output logic KEY_DOWN_1,
  output logic KEY_UP_2,
  output logic KEY_DOWN_2,
  output logic KEY_UP_3,
  output logic KEY_DOWN_3,
  output logic KEY_UP_4,
  output logic KEY_DOWN_4,
  output logic start_ball,
  output logic state,
  output logic key_release,
  output logic frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rxState_e;

  // Input conditioning
  logic [1:0]    ps2cSync_q;
  logic [1:0]    ps2dSync_q;
  logic [FW-1:0] filtCnt_q;
  logic          fc_q;
  logic          fcPrev_q;
  logic          fall;
  logic          dataBit;

  // Receiver
  rxState_e      rxState_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] toCnt_q;
  logic          rxDone_q;
  logic [7:0]    rxByte_q;
  logic          frameErr_q;

  // Decoder; keys bit order: UP_1, DOWN_1, UP_2, DOWN_2, UP_3, DOWN_3, UP_4, DOWN_4
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    keys_q, keys_d;
  logic          spaceHeld_q, spaceHeld_d;
  logic          escHeld_q, escHeld_d;
  logic          modeState_q, modeState_d;
  logic          startBall_q, startBall_d;
  logic          keyRelease_q, keyRelease_d;
  logic [7:0]    keyHit;
  logic          spaceHit;
  logic          escHit;

  // Synchronizers reset to the idle-high line level so leaving reset never
  // looks like a clock edge. The filtered clock only follows the synchronized
  // clock once it has disagreed for FILTER_LEN consecutive samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps2cSync_q <= 2'b11;
      ps2dSync_q <= 2'b11;
      filtCnt_q  <= '0;
      fc_q       <= 1'b1;
      fcPrev_q   <= 1'b1;
    end else begin
      ps2cSync_q <= {ps2cSync_q[0], ps2c};
      ps2dSync_q <= {ps2dSync_q[0], ps2d};
      fcPrev_q   <= fc_q;
      if (ps2cSync_q[1] == fc_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
        fc_q      <= ps2cSync_q[1];
        filtCnt_q <= '0;
      end else begin
        filtCnt_q <= filtCnt_q + FW'(1);
      end
    end
  end

  assign fall    = fcPrev_q & ~fc_q;
  assign dataBit = ps2dSync_q[1];

  // Frame receiver. The timeout counter measures time since the last falling
  // edge and only runs while a frame is in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxState_q  <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      toCnt_q    <= '0;
      rxDone_q   <= 1'b0;
      rxByte_q   <= '0;
      frameErr_q <= 1'b0;
    end else begin
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
      if (rxState_q == IDLE || fall) begin
        toCnt_q <= '0;
      end else begin
        toCnt_q <= toCnt_q + TW'(1);
      end

      if (rxState_q != IDLE && toCnt_q == TW'(TIMEOUT)) begin
        rxState_q  <= IDLE;
        frameErr_q <= 1'b1;
        toCnt_q    <= '0;
      end else if (fall) begin
        case (rxState_q)
          IDLE: begin
            if (!dataBit) begin
              rxState_q <= DATA;
              bitCnt_q  <= '0;
            end else begin
              frameErr_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= {dataBit, shift_q[7:1]};
            if (bitCnt_q == 3'd7) begin
              rxState_q <= PARITY;
            end else begin
              bitCnt_q <= bitCnt_q + 3'd1;
            end
          end
          PARITY: begin
            parity_q  <= dataBit;
            rxState_q <= STOP;
          end
          STOP: begin
            // Odd parity: data bits plus parity bit must hold an odd count of ones.
            if (dataBit && (^{shift_q, parity_q})) begin
              rxDone_q <= 1'b1;
              rxByte_q <= shift_q;
            end else begin
              frameErr_q <= 1'b1;
            end
            rxState_q <= IDLE;
          end
          default: rxState_q <= IDLE;
        endcase
      end
    end
  end

  // Key map, selected by whether an E0 prefix preceded the code.
  always_comb begin
    keyHit   = '0;
    spaceHit = 1'b0;
    escHit   = 1'b0;
    if (ext_q) begin
      case (rxByte_q)
        8'h75:   keyHit[2] = 1'b1;
        8'h72:   keyHit[3] = 1'b1;
        default: ;
      endcase
    end else begin
      case (rxByte_q)
        8'h1D:   keyHit[0] = 1'b1;
        8'h1B:   keyHit[1] = 1'b1;
        8'h2C:   keyHit[4] = 1'b1;
        8'h34:   keyHit[5] = 1'b1;
        8'h75:   keyHit[6] = 1'b1;
        8'h72:   keyHit[7] = 1'b1;
        8'h29:   spaceHit  = 1'b1;
        8'h76:   escHit    = 1'b1;
        default: ;
      endcase
    end
  end

  // Prefix tracking and held-key bookkeeping. Space and Esc act only on the
  // transition from released to held, so typematic repeats are ignored.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    keys_d       = keys_q;
    spaceHeld_d  = spaceHeld_q;
    escHeld_d    = escHeld_q;
    modeState_d  = modeState_q;
    startBall_d  = 1'b0;
    keyRelease_d = 1'b0;
    if (frameErr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rxDone_q) begin
      if (rxByte_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (rxByte_q == CODE_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (brk_q) begin
          keys_d       = keys_q & ~keyHit;
          keyRelease_d = 1'b1;
          if (spaceHit) spaceHeld_d = 1'b0;
          if (escHit)   escHeld_d   = 1'b0;
        end else begin
          keys_d = keys_q | keyHit;
          if (spaceHit) begin
            spaceHeld_d = 1'b1;
            startBall_d = ~spaceHeld_q;
          end
          if (escHit) begin
            escHeld_d = 1'b1;
            if (!escHeld_q) modeState_d = ~modeState_q;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keys_q       <= '0;
      spaceHeld_q  <= 1'b0;
      escHeld_q    <= 1'b0;
      modeState_q  <= 1'b0;
      startBall_q  <= 1'b0;
      keyRelease_q <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keys_q       <= keys_d;
      spaceHeld_q  <= spaceHeld_d;
      escHeld_q    <= escHeld_d;
      modeState_q  <= modeState_d;
      startBall_q  <= startBall_d;
      keyRelease_q <= keyRelease_d;
    end
  end

  assign KEY_UP_1    = keys_q[0];
  assign KEY_DOWN_1  = keys_q[1];
  assign KEY_UP_2    = keys_q[2];
  assign KEY_DOWN_2  = keys_q[3];
  assign KEY_UP_3    = keys_q[4];
  assign KEY_DOWN_3  = keys_q[5];
  assign KEY_UP_4    = keys_q[6];
  assign KEY_DOWN_4  = keys_q[7];
  assign start_ball  = startBall_q;
  assign state       = modeState_q;
  assign key_release = keyRelease_q;
  assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Drives PS/2 frames into ps2_key_decoder (directed scenarios followed by
//   random key traffic) and compares the outputs with a key-state model.

module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TOUT = 2000;
  localparam int H    = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic ps2d  = 1'b1;
  logic ps2c  = 1'b1;
  logic KEY_UP_1, KEY_DOWN_1, KEY_UP_2, KEY_DOWN_2;
  logic KEY_UP_3, KEY_DOWN_3, KEY_UP_4, KEY_DOWN_4;
  logic start_ball, state, key_release, frame_err;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [7:0] mKeys  = '0;
  logic       mSpace = 1'b0;
  logic       mEsc   = 1'b0;
  logic       mMode  = 1'b0;
  logic       mExt   = 1'b0;
  logic       mBrk   = 1'b0;
  int         mStart = 0;
  int         mRel   = 0;
  int         mErr   = 0;

  // Observed pulse counts
  int   nStart = 0;
  int   nRel   = 0;
  int   nErr   = 0;
  int   wideCnt = 0;
  logic pS = 1'b0, pR = 1'b0, pE = 1'b0;

  int         keyLat;
  int         errLat;
  logic [7:0] keysBefore;

  logic [7:0]  keysObs;
  logic [11:0] allOuts;

  assign keysObs = {KEY_DOWN_4, KEY_UP_4, KEY_DOWN_3, KEY_UP_3,
                    KEY_DOWN_2, KEY_UP_2, KEY_DOWN_1, KEY_UP_1};
  assign allOuts = {keysObs, start_ball, state, key_release, frame_err};

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c),
    .KEY_UP_1(KEY_UP_1), .KEY_DOWN_1(KEY_DOWN_1),
    .KEY_UP_2(KEY_UP_2), .KEY_DOWN_2(KEY_DOWN_2),
    .KEY_UP_3(KEY_UP_3), .KEY_DOWN_3(KEY_DOWN_3),
    .KEY_UP_4(KEY_UP_4), .KEY_DOWN_4(KEY_DOWN_4),
    .start_ball(start_ball), .state(state),
    .key_release(key_release), .frame_err(frame_err)
  );

  // Pulse counting, including detection of any pulse wider than one cycle.
  always @(negedge clk) begin
    if (start_ball)  nStart <= nStart + 1;
    if (key_release) nRel   <= nRel + 1;
    if (frame_err)   nErr   <= nErr + 1;
    if ((start_ball && pS) || (key_release && pR) || (frame_err && pE))
      wideCnt <= wideCnt + 1;
    pS <= start_ball;
    pR <= key_release;
    pE <= frame_err;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Key table: 0..7 paddle flags, 8 Space, 9 Esc, -1 unmapped.
  function automatic int keyIndex(input logic ext, input logic [7:0] code);
    if (ext) begin
      if (code == 8'h75) return 2;
      if (code == 8'h72) return 3;
      return -1;
    end
    case (code)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h2C: return 4;
      8'h34: return 5;
      8'h75: return 6;
      8'h72: return 7;
      8'h29: return 8;
      8'h76: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    int idx;
    if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      idx = keyIndex(mExt, b);
      if (mBrk) begin
        mRel++;
        if (idx >= 0 && idx < 8) mKeys[idx] = 1'b0;
        if (idx == 8) mSpace = 1'b0;
        if (idx == 9) mEsc = 1'b0;
      end else begin
        if (idx >= 0 && idx < 8) mKeys[idx] = 1'b1;
        if (idx == 8) begin
          if (!mSpace) mStart++;
          mSpace = 1'b1;
        end
        if (idx == 9) begin
          if (!mEsc) mMode = ~mMode;
          mEsc = 1'b1;
        end
      end
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endfunction

  // One PS/2 bit; records when keys/frame_err react after the falling edge.
  task automatic ps2Bit(input logic b);
    ps2d = b;
    repeat (H) @(negedge clk);
    ps2c = 1'b0;
    keysBefore = keysObs;
    keyLat = -1;
    errLat = -1;
    for (int i = 1; i <= H; i++) begin
      @(negedge clk);
      if (keyLat < 0 && keysObs != keysBefore) keyLat = i;
      if (errLat < 0 && frame_err) errLat = i;
    end
    ps2c = 1'b1;
  endtask

  // fault: 0 good frame, 1 bad parity, 2 bad stop bit
  task automatic applyStimulus(input logic [7:0] b, input int fault);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit((~^b) ^ (fault == 1));
    ps2Bit(fault != 2);
    ps2d = 1'b1;
    repeat (H) @(negedge clk);
    if (fault == 0) begin
      modelByte(b);
    end else begin
      mErr++;
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".keys"},   32'(keysObs), 32'(mKeys));
    checkOutput({tag, ".state"},  32'(state),   32'(mMode));
    checkOutput({tag, ".starts"}, nStart,       mStart);
    checkOutput({tag, ".rels"},   nRel,         mRel);
    checkOutput({tag, ".errs"},   nErr,         mErr);
  endtask

  task automatic randomEvent(input int n);
    logic [7:0] codes [10];
    logic [7:0] code;
    logic [7:0] seq [$];
    logic       ext;
    logic       isBreak;
    int         reps;
    codes = '{8'h1D, 8'h1B, 8'h2C, 8'h34, 8'h75, 8'h72, 8'h29, 8'h76, 8'h15, 8'h4D};
    code = codes[$urandom_range(0, 9)];
    ext = (code == 8'h75 || code == 8'h72 || code == 8'h15) ? 1'($urandom_range(0, 1)) : 1'b0;
    isBreak = 1'($urandom_range(0, 1));
    seq.delete();
    if (isBreak) begin
      if (ext && $urandom_range(0, 1) == 1) begin
        seq.push_back(8'hF0);
        seq.push_back(8'hE0);
      end else begin
        if (ext) seq.push_back(8'hE0);
        seq.push_back(8'hF0);
      end
      seq.push_back(code);
    end else begin
      reps = $urandom_range(1, 2);
      for (int r = 0; r < reps; r++) begin
        if (ext) seq.push_back(8'hE0);
        seq.push_back(code);
      end
    end
    foreach (seq[k]) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(1, 2)));
      applyStimulus(seq[k], 0);
    end
    checkAll($sformatf("rand%0d", n));
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset.outs", 32'(allOuts), 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // W make, with latency from the stop-bit clock edge
    applyStimulus(8'h1D, 0);
    checkOutput("w_make.lat", keyLat, 2 + FILT + 2);
    checkAll("w_make");
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h1D, 0);
    checkAll("w_break");

    // Extended vs plain up arrow
    applyStimulus(8'hE0, 0);
    applyStimulus(8'h75, 0);
    applyStimulus(8'h75, 0);
    checkAll("arrows_make");
    applyStimulus(8'hE0, 0);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h75, 0);
    checkAll("arrow2_break");

    // Space typematic, then release and press again
    repeat (3) applyStimulus(8'h29, 0);
    checkAll("space_typematic");
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h29, 0);
    applyStimulus(8'h29, 0);
    checkAll("space_repress");

    // Release keypad 8, then a parity error and a prefix wiped by a bad frame
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h75, 0);
    applyStimulus(8'h1D, 1);
    checkOutput("parity.lat", errLat, 2 + FILT + 1);
    checkAll("parity_err");
    applyStimulus(8'hE0, 0);
    applyStimulus(8'h33, 2);
    applyStimulus(8'h75, 0);
    checkAll("prefix_cleared");

    // Stalled frame after 4 data bits, with a pending E0 that must be dropped
    applyStimulus(8'hE0, 0);
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(1'($urandom_range(0, 1)));
    ps2d = 1'b1;
    repeat (TOUT + 1000) @(negedge clk);
    mErr++;
    mExt = 1'b0;
    mBrk = 1'b0;
    checkAll("timeout");
    applyStimulus(8'h2C, 0);
    checkAll("after_timeout");

    // Lone falling edge with data high is a bad start bit
    ps2Bit(1'b1);
    repeat (H) @(negedge clk);
    mErr++;
    checkAll("bad_start");

    // Short ps2c glitches must not register as clock edges
    for (int g = 0; g < 5; g++) begin
      ps2c = 1'b0;
      repeat (FILT - 3) @(negedge clk);
      ps2c = 1'b1;
      repeat (H) @(negedge clk);
    end
    checkAll("glitch");

    for (int n = 0; n < 25; n++) randomEvent(n);

    // Reset mid-frame with S held and mode set
    if (!mMode) begin
      if (mEsc) begin
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h76, 0);
      end
      applyStimulus(8'h76, 0);
    end
    applyStimulus(8'h1B, 0);
    checkOutput("pre_reset.s", 32'(KEY_DOWN_1), 32'h1);
    checkOutput("pre_reset.state", 32'(state), 32'h1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset.outs", 32'(allOuts), 32'h0);
    reset = 1'b1;
    mKeys = '0; mSpace = 1'b0; mEsc = 1'b0; mMode = 1'b0; mExt = 1'b0; mBrk = 1'b0;
    repeat (TOUT + 200) @(negedge clk);
    checkAll("post_reset");
    applyStimulus(8'h1D, 0);
    checkAll("post_reset_frame");

    checkOutput("pulse_width", wideCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
